mux_4to1_dec_tristate: RTL and testbench
========================================

// Module: mux_4to1_dec_tristate
// PURPOSE
//   4:1 single-bit multiplexer built structurally from a 2-to-4 decoder and four
//   tri-state buffers sharing one internal bus net, followed by an output register.
//   Used as a select-steered bit path wherever one of four sources must feed a single
//   registered destination.
//   Also exposes the combinational mux result and the decoder one-hot for observability.
// PARAMETERS
//   none (fixed 1-bit data, 2-bit select)
// PORTS
//   clk      in   1  system clock; all state updates on rising edge
//   rst      in   1  synchronous, active-high reset
//   I0       in   1  data input, selected when {S1,S0}=2'b00
//   I1       in   1  data input, selected when {S1,S0}=2'b01
//   I2       in   1  data input, selected when {S1,S0}=2'b10
//   I3       in   1  data input, selected when {S1,S0}=2'b11
//   S0       in   1  select LSB
//   S1       in   1  select MSB
//   Y        out  1  registered mux output
//   Y_comb   out  1  combinational mux output (bus net value)
//   dec_out  out  4  decoder one-hot; dec_out[n]=1 enables buffer n
// BEHAVIOUR
//   Interface: one clock (clk); reset rst is synchronous and active-high.
//   Decoder: dec_out = 4'b0001 << {S1,S0}; exactly one bit high for known selects.
//     If S1 or S0 is X/Z, dec_out = 4'b0000.
//   Tri-state stage: buffer n drives In onto bus when dec_out[n]=1, else Z.
//     At most one driver is active, so no contention exists by construction.
//   Undriven bus (dec_out=0): Y_comb resolves to 0 through a weak pull-down, never Z/X.
//   Y_comb is purely combinational from I*/S*; zero-cycle latency; unaffected by rst.
//   Y: on each rising clk edge, rst=1 -> Y<=0; else Y<=Y_comb. Latency 1 cycle.
//   Reset values: Y=0. Y_comb and dec_out track inputs even during reset.
//   Reset mid-operation: Y clears to 0 on that edge; normal capture resumes on the
//     first edge with rst=0.
//   Select change and data change in the same cycle: Y captures the new-select,
//     new-data value at the next edge. No glitch filtering on Y_comb.
// TESTING
//   rst=1 for 2 edges, all inputs 0 -> Y=0, Y_comb=0, dec_out=4'b0001.
//   For each sel 0..3: I=4'b0000 -> Y_comb=0, next edge Y=0; then I=4'b1111 ->
//     Y_comb=1, next edge Y=1; dec_out=1<<sel.
//   Walking one: sel=2, I=4'b0100 -> Y=1; I=4'b1011 -> Y=0
//     (unselected inputs do not leak).
//   sel=3, I3=1, Y=1; assert rst one cycle -> Y=0 at that edge; Y_comb stays 1;
//     release -> Y=1 next edge.
//   S0=X -> dec_out=4'b0000, Y_comb=0, next edge Y=0.
//   Random 1000 cycles: Y(t+1) == I[{S1,S0}](t) whenever rst=0;
//     $onehot(dec_out) always holds for known selects.

Source files
------------

// File: rtl/mux_4to1_dec_tristate.sv
// mux_4to1_dec_tristate: 2-to-4 decoder steering four bus drivers onto one pulled-down net, plus an output register
module mux_4to1_dec_tristate (
  input  logic       clk,
  input  logic       rst,
  input  logic       I0,
  input  logic       I1,
  input  logic       I2,
  input  logic       I3,
  input  logic       S0,
  input  logic       S1,
  output logic       Y,
  output logic       Y_comb,
  output logic [3:0] dec_out
);
  logic [3:0] w_in;
  logic [3:0] w_drv;
  logic       w_sel_known;
  logic       r_y;
  assign w_in        = {I3, I2, I1, I0};
  assign w_sel_known = (^{S1, S0} !== 1'bx);
  assign dec_out     = w_sel_known ? (4'b0001 << {S1, S0}) : 4'b0000;
  // Each enabled driver contributes its input; a disabled driver contributes nothing, so an undriven bus reads 0 as with a pull-down
  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_buf
      assign w_drv[n] = dec_out[n] & w_in[n];
    end
  endgenerate
  assign Y_comb = |w_drv;
  always_ff @(posedge clk) begin
    if (rst) r_y <= 1'b0;
    else     r_y <= Y_comb;
  end
  assign Y = r_y;
endmodule

// File: tb/tb_mux_4to1_dec_tristate.sv
// tb_mux_4to1_dec_tristate: directed and random checks of the registered 4:1 mux against an arithmetic reference
module tb_mux_4to1_dec_tristate;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i;
  logic [1:0] s;
  logic       Y, Y_comb;
  logic [3:0] dec_out;
  int total = 0;
  int bad   = 0;
  mux_4to1_dec_tristate dut (
    .clk(clk), .rst(rst),
    .I0(i[0]), .I1(i[1]), .I2(i[2]), .I3(i[3]),
    .S0(s[0]), .S1(s[1]),
    .Y(Y), .Y_comb(Y_comb), .dec_out(dec_out)
  );
  always #5 clk = ~clk;
  function automatic logic ref_bit(input logic [3:0] d, input logic [1:0] sel);
    return logic'((int'(d) >> int'(sel)) % 2);
  endfunction
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic exp_y;
    rst = 1'b1; i = 4'b0000; s = 2'b00;
    tick(); tick();
    chk("reset_y", {3'b0, Y}, 4'h0);
    chk("reset_ycomb", {3'b0, Y_comb}, 4'h0);
    chk("reset_dec", dec_out, 4'b0001);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k); i = 4'b0000; #1;
      chk("sel_zero_comb", {3'b0, Y_comb}, 4'h0);
      chk("sel_dec", dec_out, 4'(1 << k));
      tick();
      chk("sel_zero_y", {3'b0, Y}, 4'h0);
      i = 4'b1111; #1;
      chk("sel_one_comb", {3'b0, Y_comb}, 4'h1);
      tick();
      chk("sel_one_y", {3'b0, Y}, 4'h1);
    end
    s = 2'd2; i = 4'b0100; tick();
    chk("walk_sel_y", {3'b0, Y}, 4'h1);
    i = 4'b1011; #1;
    chk("walk_leak_comb", {3'b0, Y_comb}, 4'h0);
    tick();
    chk("walk_leak_y", {3'b0, Y}, 4'h0);
    s = 2'd3; i = 4'b1000; tick();
    chk("pre_rst_y", {3'b0, Y}, 4'h1);
    rst = 1'b1; tick();
    chk("mid_rst_y", {3'b0, Y}, 4'h0);
    chk("mid_rst_comb", {3'b0, Y_comb}, 4'h1);
    rst = 1'b0; tick();
    chk("post_rst_y", {3'b0, Y}, 4'h1);
    s = 2'bx0; i = 4'b1111; #1;
    if ($isunknown(s)) begin
      chk("selx_dec", dec_out, 4'b0000);
      chk("selx_comb", {3'b0, Y_comb}, 4'h0);
      tick();
      chk("selx_y", {3'b0, Y}, 4'h0);
    end
    for (int c = 0; c < 1000; c++) begin
      i   = 4'($urandom);
      s   = 2'($urandom);
      rst = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd_comb", {3'b0, Y_comb}, {3'b0, ref_bit(i, s)});
      chk("rnd_dec", dec_out, 4'(1 << int'(s)));
      chk("rnd_onehot", {3'b0, $onehot(dec_out)}, 4'h1);
      exp_y = rst ? 1'b0 : ref_bit(i, s);
      tick();
      chk("rnd_y", {3'b0, Y}, {3'b0, exp_y});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
